core_muldiv_unit: RTL

Parametrised iterative multiply/divide unit that sits beside the ALU in the execute (X) stage of the pipelined MIPS core and owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from X, computes products and quotients over several cycles, and raises a stall request to the hazard unit so that dependent MFHI/MFLO or a second multi-cycle op waits. It generalises the single-cycle ALU path to a WIDTH-bit, multi-cycle, handshaked functional unit.

---
 rtl/core_muldiv_unit_if.sv | 27 ++
 rtl/core_muldiv_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/core_muldiv_unit_if.sv
// X-stage <-> muldiv unit bundle: op issue, hazard feedback and architectural HI/LO.
interface core_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_x;
  logic [2:0]       op_x;
  logic [WIDTH-1:0] src_a_x;
  logic [WIDTH-1:0] src_b_x;
  logic             hilo_read_x;
  logic             flush_x;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic             illegal_op;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start_x, op_x, src_a_x, src_b_x, hilo_read_x, flush_x,
    input  stall_req, busy, done, illegal_op, hi, lo
  );

  modport slave (
    input  start_x, op_x, src_a_x, src_b_x, hilo_read_x, flush_x,
    output stall_req, busy, done, illegal_op, hi, lo
  );
endinterface

// File: rtl/core_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO, one bit per cycle.
// Define CORE_MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are illegal ops.
module core_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  core_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

`ifdef CORE_MULDIV_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;
`endif

  state_t state_q, state_d;

  // mul: {partial product hi, multiplier}; div: {remainder, dividend -> quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [CW-1:0]      cnt_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, ill_q;

  logic               idle, accept, last, sgn;
  logic               op_mul, op_div, op_mth, op_mtl;
  logic [WIDTH-1:0]   mag_a, mag_b, addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign idle   = (state_q == S_IDLE);
  assign accept = idle & bus.start_x & ~bus.flush_x;
  assign last   = (cnt_q == CW'(WIDTH-1));
  assign sgn    = ~bus.op_x[0];
  assign op_mul = (bus.op_x[2:1] == 2'b00);
`ifdef CORE_MULDIV_DIV_EN
  assign op_div = (bus.op_x[2:1] == 2'b01);
`else
  assign op_div = 1'b0;
`endif
  assign op_mth = (bus.op_x == 3'b100);
  assign op_mtl = (bus.op_x == 3'b101);

  assign mag_a = (sgn & bus.src_a_x[WIDTH-1]) ? -bus.src_a_x : bus.src_a_x;
  assign mag_b = (sgn & bus.src_b_x[WIDTH-1]) ? -bus.src_b_x : bus.src_b_x;

  assign addend  = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

`ifdef CORE_MULDIV_DIV_EN
  logic [WIDTH-1:0] a_q;
  logic             is_div_q, neg_r_q, dz_q;
  logic [WIDTH:0]   div_shift, div_diff;

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
`endif

  always_comb begin
    fix_prod = neg_q ? -acc_q : acc_q;
    fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
    fix_lo   = fix_prod[WIDTH-1:0];
`ifdef CORE_MULDIV_DIV_EN
    if (is_div_q) begin
      fix_lo = neg_q   ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
      fix_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      // divide by zero reports the original dividend, not the magnitude left in acc
      if (dz_q) begin
        fix_lo = {WIDTH{1'b1}};
        fix_hi = a_q;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && op_mul)      state_d = S_MUL;
        else if (accept && op_div) begin
`ifdef CORE_MULDIV_DIV_EN
          state_d = S_DIV;
`endif
        end
      end
      S_MUL: if (last) state_d = S_FIX;
`ifdef CORE_MULDIV_DIV_EN
      S_DIV: if (last) state_d = S_FIX;
`endif
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
`ifdef CORE_MULDIV_DIV_EN
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          cnt_q <= '0;
          neg_q <= sgn & (bus.src_a_x[WIDTH-1] ^ bus.src_b_x[WIDTH-1]);
`ifdef CORE_MULDIV_DIV_EN
          is_div_q <= op_div;
          neg_r_q  <= sgn & bus.src_a_x[WIDTH-1];
          dz_q     <= (bus.src_b_x == '0);
          a_q      <= bus.src_a_x;
`endif
          if (op_mul) begin
            acc_q  <= {{WIDTH{1'b0}}, mag_b};
            opnd_q <= mag_a;
          end
`ifdef CORE_MULDIV_DIV_EN
          else if (op_div) begin
            acc_q  <= {{WIDTH{1'b0}}, mag_a};
            opnd_q <= mag_b;
          end
`endif
          else if (op_mth) hi_q  <= bus.src_a_x;
          else if (op_mtl) lo_q  <= bus.src_a_x;
          else             ill_q <= 1'b1;
        end
        S_MUL: begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 1'b1;
        end
`ifdef CORE_MULDIV_DIV_EN
        S_DIV: begin
          // restore by keeping the shifted value when the trial subtract goes negative
          if (div_diff[WIDTH]) acc_q <= {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else                 acc_q <= {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
          cnt_q <= cnt_q + 1'b1;
        end
`endif
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = ~idle;
  assign bus.stall_req  = ~idle & (bus.start_x | bus.hilo_read_x);
  assign bus.done       = done_q;
  assign bus.illegal_op = ill_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
endmodule
